// File: rtl/alu32_multicycle_pkg.sv
// Shared opcode/state encodings and sizing helpers for the sliced 32-bit ALU.
package alu32_multicycle_pkg;

  typedef enum logic [2:0] {
    OP_NOTA = 3'b000,
    OP_NOTB = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ADD  = 3'b110,
    OP_SUB  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DATA_W = 32;

  function automatic int steps_of(input int slice_w);
    return DATA_W / slice_w;
  endfunction

  // A one-step configuration still needs a 1-bit counter to stay well-formed.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/alu32_multicycle_slice.sv
// Combinational W-bit ALU slice: logic result plus add and subtract carry chains.
module alu32_multicycle_slice
  import alu32_multicycle_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin_add,
  input  logic         cin_sub,
  output logic [W-1:0] res,
  output logic         cout_add,
  output logic         cout_sub,
  output logic         cmsb_add,
  output logic         cmsb_sub
);

  logic [W-1:0] b_inv;
  logic [W:0]   sum_add;
  logic [W:0]   sum_sub;

  assign b_inv   = ~b;
  assign sum_add = {1'b0, a} + {1'b0, b}     + {{W{1'b0}}, cin_add};
  assign sum_sub = {1'b0, a} + {1'b0, b_inv} + {{W{1'b0}}, cin_sub};

  assign cout_add = sum_add[W];
  assign cout_sub = sum_sub[W];
  // Carry into the top bit falls out of the sum bit and its two addend bits.
  assign cmsb_add = sum_add[W-1] ^ a[W-1] ^ b[W-1];
  assign cmsb_sub = sum_sub[W-1] ^ a[W-1] ^ b_inv[W-1];

  always_comb begin
    res = '0;
    case (op)
      OP_NOTA: res = ~a;
      OP_NOTB: res = b_inv;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_ADD:  res = sum_add[W-1:0];
      default: res = sum_sub[W-1:0];
    endcase
  end

endmodule

// File: rtl/alu32_multicycle.sv
// Multi-cycle 32-bit ALU: walks SLICE_W-bit slices LSB first, then pulses done.
module alu32_multicycle
  import alu32_multicycle_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [2:0]  op_out,
  output logic [31:0] result,
  output logic        co_add,
  output logic        co_prev_add,
  output logic        co_sub,
  output logic        co_prev_sub
);

  localparam int STEPS = steps_of(SLICE_W);
  localparam int CNT_W = cnt_width(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_e             state_reg;
  logic [31:0]        a_reg;
  logic [31:0]        b_reg;
  logic [CNT_W-1:0]   step_reg;
  logic               carry_add_reg;
  logic               carry_sub_reg;

  logic [5:0]         bit_base;
  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W-1:0] res_slice;
  logic               cout_add;
  logic               cout_sub;
  logic               cmsb_add;
  logic               cmsb_sub;

  assign bit_base = 6'(int'(step_reg) * SLICE_W);
  assign a_slice  = a_reg[bit_base +: SLICE_W];
  assign b_slice  = b_reg[bit_base +: SLICE_W];

  alu32_multicycle_slice #(
    .W(SLICE_W)
  ) u_slice (
    .op       (op_out),
    .a        (a_slice),
    .b        (b_slice),
    .cin_add  (carry_add_reg),
    .cin_sub  (carry_sub_reg),
    .res      (res_slice),
    .cout_add (cout_add),
    .cout_sub (cout_sub),
    .cmsb_add (cmsb_add),
    .cmsb_sub (cmsb_sub)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      op_out        <= '0;
      result        <= '0;
      co_add        <= 1'b0;
      co_prev_add   <= 1'b0;
      co_sub        <= 1'b0;
      co_prev_sub   <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      step_reg      <= '0;
      carry_add_reg <= 1'b0;
      carry_sub_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // The done cycle is spent here with busy still high, so a start
          // arriving alongside done is dropped rather than accepted.
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !busy) begin
            a_reg         <= a;
            b_reg         <= b;
            op_out        <= op;
            step_reg      <= '0;
            carry_add_reg <= 1'b0;
            carry_sub_reg <= 1'b1;
            busy          <= 1'b1;
            state_reg     <= ST_RUN;
          end
        end
        ST_RUN: begin
          result[bit_base +: SLICE_W] <= res_slice;
          carry_add_reg <= cout_add;
          carry_sub_reg <= cout_sub;
          if (step_reg == LAST_STEP) begin
            co_add      <= cout_add;
            co_prev_add <= cmsb_add;
            co_sub      <= cout_sub;
            co_prev_sub <= cmsb_sub;
            state_reg   <= ST_DONE;
          end else begin
            step_reg <= step_reg + 1'b1;
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
